// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: turns bit-reversed (or natural) FFT frames of 2**N_LOG2
// complex bins into contiguous natural-order output with a bin index.
module fft_bitrev_reorder #(
    parameter int N_LOG2       = 10,
    parameter int DATA_WIDTH   = 25,
    parameter bit BITREV_INPUT = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] data_re_i,
    input  logic signed [DATA_WIDTH-1:0] data_im_i,
    output logic                         sync_o,
    output logic [N_LOG2-1:0]            data_ctr_o,
    output logic signed [DATA_WIDTH-1:0] data_re_o,
    output logic signed [DATA_WIDTH-1:0] data_im_o,
    output logic                         frame_err_o
);

    localparam logic [N_LOG2-1:0] LAST_IDX = '1;
    localparam int                DEPTH    = 2 << N_LOG2;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_t;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
        logic [N_LOG2-1:0] res;
        for (int i = 0; i < N_LOG2; i++) begin
            res[i] = a[N_LOG2-1-i];
        end
        return res;
    endfunction

    logic [2*DATA_WIDTH-1:0]      r_mem [DEPTH];

    logic [N_LOG2-1:0]            r_wctr;
    logic                         r_wbank;
    logic                         r_frame_err;
    logic [1:0]                   r_full;
    rd_state_t                    r_state;
    logic [N_LOG2-1:0]            r_raddr;
    logic                         r_rbank;
    logic                         r_sync;
    logic [N_LOG2-1:0]            r_ctr;
    logic signed [DATA_WIDTH-1:0] r_re;
    logic signed [DATA_WIDTH-1:0] r_im;

    logic [N_LOG2-1:0]            w_waddr;
    logic                         w_wr_last;
    logic                         w_rd_last;
    logic [1:0]                   w_full_set;
    logic [1:0]                   w_full_clr;
    logic [1:0]                   w_full_next;

    assign w_waddr   = BITREV_INPUT ? bitrev(r_wctr) : r_wctr;
    assign w_wr_last = valid_i && (r_wctr == LAST_IDX);
    assign w_rd_last = (r_state == RD_READ) && (r_raddr == LAST_IDX);

    // Writer's set and reader's clear can land on the same cycle; both take effect.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_full_set = '0;
        w_full_clr = '0;
        if (w_wr_last) w_full_set[r_wbank] = 1'b1;
        if (w_rd_last) w_full_clr[r_rbank] = 1'b1;
        w_full_next = (r_full & ~w_full_clr) | w_full_set;
    end

    // NOTE: the sample storage is deliberately not reset; the full flags guard it.
    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            r_mem[{r_wbank, w_waddr}] <= {data_re_i, data_im_i};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments to avoid update-order races.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wctr      <= '0;
            r_wbank     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (valid_i) begin
                r_wctr <= r_wctr + 1'b1;
                if (w_wr_last) r_wbank <= ~r_wbank;
            end else if (r_wctr != '0) begin
                // Partial frame: drop it without marking the bank full.
                r_frame_err <= 1'b1;
                r_wctr      <= '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RD_IDLE;
            r_raddr <= '0;
            r_rbank <= 1'b0;
            r_full  <= '0;
            r_sync  <= 1'b0;
            r_ctr   <= '0;
            r_re    <= '0;
            r_im    <= '0;
        end else begin
            r_full <= w_full_next;
            r_sync <= 1'b0;
            r_ctr  <= '0;
            r_re   <= '0;
            r_im   <= '0;
            case (r_state)
                RD_IDLE: begin
                    if (r_full[r_rbank]) begin
                        r_state <= RD_READ;
                        r_raddr <= '0;
                    end
                end
                RD_READ: begin
                    r_sync         <= 1'b1;
                    r_ctr          <= r_raddr;
                    {r_re, r_im}   <= r_mem[{r_rbank, r_raddr}];
                    r_raddr        <= r_raddr + 1'b1;
                    if (w_rd_last) begin
                        // Chain straight into the other bank if it is ready, for gapless output.
                        r_rbank <= ~r_rbank;
                        r_state <= w_full_next[~r_rbank] ? RD_READ : RD_IDLE;
                    end
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

    assign sync_o      = r_sync;
    assign data_ctr_o  = r_ctr;
    assign data_re_o   = r_re;
    assign data_im_o   = r_im;
    assign frame_err_o = r_frame_err;

endmodule
